// File: rtl/vram_loader_pkg.sv
// Shared constants and state encoding for the VRAM stream loader.
// Screen geometry, frame header/select bytes and FSM states live here.
package vram_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_SEL  = 3'd2,
      ST_PIX  = 3'd3,
      ST_CHK  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] SEL_GAME  = 8'h00;
   localparam logic [7:0] SEL_SEIBA = 8'h01;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 360;
   localparam int VRAM_DEPTH    = SCREEN_WIDTH * SCREEN_HEIGHT;

   function automatic logic is_sel_byte(input logic [7:0] b);
      return (b == SEL_GAME) || (b == SEL_SEIBA);
   endfunction

endpackage

// File: rtl/vram_checksum8.sv
// 8-bit modular running sum of pixel bytes with an equality compare
// against a trailer byte. Used only when VRAM_LOADER_CHECKSUM_EN is defined.
module vram_checksum8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       add,
   input  logic [7:0] data,
   input  logic [7:0] cmp,
   output logic       match
);

   logic [7:0] sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= 8'h00;
      end else if (clear) begin
         sum <= 8'h00;
      end else if (add) begin
         sum <= sum + data;
      end
   end

   assign match = (sum == cmp);

endmodule

// File: rtl/vram_stream_loader.sv
// Loads one frame from a valid/ready byte stream into a selected VRAM buffer.
// Optional trailer checksum check is built when VRAM_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for i_start
// HDR   | discarding bytes until the sync byte
// SEL   | next byte picks the target buffer (0 game, 1 seiba)
// PIX   | one pixel write per accepted byte
// CHK   | trailer byte compared against the running sum (checksum build only)
// DONE  | one-cycle completion pulse
module vram_stream_loader #(
   parameter int         ADDR_WIDTH = 18,
   parameter int         DATA_WIDTH = 6,
   parameter int         DEPTH      = vram_loader_pkg::VRAM_DEPTH,
   parameter logic [7:0] SYNC_BYTE  = vram_loader_pkg::SYNC_BYTE
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [7:0]            i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_vram_sel,
   output logic [ADDR_WIDTH-1:0] o_vram_addr,
   output logic [DATA_WIDTH-1:0] o_vram_data,
   output logic                  o_vram_write,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   import vram_loader_pkg::*;

   state_t                state;
   logic [ADDR_WIDTH-1:0] count;
   logic                  xfer;
   logic                  last_pix;
   logic                  range_bad;

   assign o_ready   = (state == ST_HDR) || (state == ST_SEL) ||
                      (state == ST_PIX) || (state == ST_CHK);
   assign o_busy    = (state != ST_IDLE);
   assign xfer      = i_valid && o_ready;
   assign last_pix  = (count == ADDR_WIDTH'(DEPTH - 1));
   assign range_bad = (i_data[7:DATA_WIDTH] != '0);

`ifdef VRAM_LOADER_CHECKSUM_EN
   logic sum_match;

   vram_checksum8 u_checksum (
      .clk   (i_clk),
      .rst   (i_rst),
      .clear (state == ST_SEL),
      .add   ((state == ST_PIX) && xfer),
      .data  (i_data),
      .cmp   (i_data),
      .match (sum_match)
   );
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         count        <= '0;
         o_vram_sel   <= 1'b0;
         o_vram_addr  <= '0;
         o_vram_data  <= '0;
         o_vram_write <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_vram_write <= 1'b0;
         o_done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state <= ST_HDR;
                  o_err <= 1'b0;
                  count <= '0;
               end
            end
            ST_HDR: begin
               if (xfer && (i_data == SYNC_BYTE)) begin
                  state <= ST_SEL;
               end
            end
            ST_SEL: begin
               if (xfer) begin
                  if (is_sel_byte(i_data)) begin
                     o_vram_sel <= i_data[0];
                     state      <= ST_PIX;
                  end else begin
                     o_err <= 1'b1;
                     state <= ST_HDR;
                  end
               end
            end
            ST_PIX: begin
               if (xfer) begin
                  o_vram_write <= 1'b1;
                  o_vram_addr  <= count;
                  o_vram_data  <= i_data[DATA_WIDTH-1:0];
                  if (range_bad) begin
                     o_err <= 1'b1;
                  end
                  if (last_pix) begin
`ifdef VRAM_LOADER_CHECKSUM_EN
                     state  <= ST_CHK;
`else
                     state  <= ST_DONE;
                     o_done <= 1'b1;
`endif
                  end else begin
                     count <= count + ADDR_WIDTH'(1);
                  end
               end
            end
`ifdef VRAM_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (xfer) begin
                  if (!sum_match) begin
                     o_err <= 1'b1;
                  end
                  state  <= ST_DONE;
                  o_done <= 1'b1;
               end
            end
`endif
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_stream_loader.sv
// Self-checking bench for vram_stream_loader with DEPTH=4: directed frames
// plus randomized frames checked against a byte-stream parsing model.
module tb_vram_stream_loader;

   localparam int DEPTH = 4;

   typedef logic [7:0] bq_t[$];

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [7:0]  i_data;
   logic        i_valid;
   logic        o_ready;
   logic        o_vram_sel;
   logic [17:0] o_vram_addr;
   logic [5:0]  o_vram_data;
   logic        o_vram_write;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   vram_stream_loader #(.DEPTH(DEPTH)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_vram_sel   (o_vram_sel),
      .o_vram_addr  (o_vram_addr),
      .o_vram_data  (o_vram_data),
      .o_vram_write (o_vram_write),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int got[$];
   int got_cyc[$];
   int done_cnt = 0;
   int exp_w[$];
   logic exp_err;

   function automatic int pack(input logic s, input logic [17:0] a, input logic [5:0] d);
      return int'({7'b0, s, a, d});
   endfunction

   always @(negedge i_clk) begin
      cyc++;
      if (o_vram_write) begin
         got.push_back(pack(o_vram_sel, o_vram_addr, o_vram_data));
         got_cyc.push_back(cyc);
      end
      if (o_done) done_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bail(input string tag);
      fails++;
      $display("FAIL %s timeout", tag);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "bound expired");
   endtask

   // Reference: parse the stream as a frame after start; the first complete frame ends it.
   task automatic model(input bq_t s);
      int i;
      logic [7:0] sum;
      logic [7:0] b;
      logic [7:0] sel;
      i = 0;
      exp_w.delete();
      exp_err = 1'b0;
      while (i < s.size()) begin
         b = s[i];
         i++;
         if (b != 8'hA5) continue;
         if (i >= s.size()) break;
         sel = s[i];
         i++;
         if (sel > 8'd1) begin
            exp_err = 1'b1;
            continue;
         end
         sum = 8'h00;
         for (int k = 0; k < DEPTH && i < s.size(); k++) begin
            b = s[i];
            i++;
            exp_w.push_back(pack(sel[0], 18'(k), b[5:0]));
            if (b[7:6] != 2'b00) exp_err = 1'b1;
            sum = sum + b;
         end
`ifdef VRAM_LOADER_CHECKSUM_EN
         if (i < s.size()) begin
            b = s[i];
            if (b != sum) exp_err = 1'b1;
         end
`endif
         break;
      end
   endtask

   function automatic logic [7:0] pix_sum(input bq_t s);
      logic [7:0] sum = 8'h00;
      for (int k = s.size() - DEPTH; k < s.size(); k++) sum = sum + s[k];
      return sum;
   endfunction

   task automatic add_trailer(inout bq_t s, input logic good);
`ifdef VRAM_LOADER_CHECKSUM_EN
      logic [7:0] t;
      t = pix_sum(s);
      s.push_back(good ? t : t + 8'd1);
`endif
   endtask

   task automatic pulse_start();
      @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic send(input bq_t s, input int gap_pct);
      foreach (s[k]) begin
         int guard;
         guard = 0;
         forever begin
            @(negedge i_clk);
            if ($urandom_range(99) < gap_pct) begin
               i_valid = 1'b0;
            end else begin
               i_valid = 1'b1;
               i_data  = s[k];
               if (o_ready) break;
            end
            guard++;
            if (guard > 200) bail("send_ready");
         end
      end
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100; n++) begin
         if (!o_busy) return;
         @(negedge i_clk);
      end
      bail("wait_idle");
   endtask

   task automatic check_frame(input string tag, input bq_t s);
      model(s);
      chk({tag, "_nwrites"}, got.size(), exp_w.size());
      for (int k = 0; k < exp_w.size() && k < got.size(); k++)
         chk($sformatf("%s_w%0d", tag, k), got[k], exp_w[k]);
      chk({tag, "_err"}, int'(o_err), int'(exp_err));
      chk({tag, "_done"}, done_cnt, 1);
   endtask

   task automatic run_frame(input string tag, input bq_t s, input int gap_pct);
      got.delete();
      got_cyc.delete();
      done_cnt = 0;
      pulse_start();
      chk({tag, "_err_clr"}, int'(o_err), 0);
      chk({tag, "_busy"}, int'(o_busy), 1);
      send(s, gap_pct);
      wait_idle();
      check_frame(tag, s);
   endtask

   initial begin
      bq_t s;
      bq_t s2;
      i_rst = 1'b1;
      i_start = 1'b0;
      i_valid = 1'b0;
      i_data = 8'h00;
      repeat (3) @(negedge i_clk);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_ready", int'(o_ready), 0);
      chk("rst_addr", int'(o_vram_addr), 0);
      chk("rst_write", int'(o_vram_write), 0);
      i_rst = 1'b0;

      // 1: reset in the middle of a frame
      pulse_start();
      s = '{8'hA5, 8'h01, 8'h05, 8'h0A};
      send(s, 0);
      chk("mid_write", int'(o_vram_write), 1);
      chk("mid_busy", int'(o_busy), 1);
      #2 i_rst = 1'b1;
      #1;
      chk("arst_write", int'(o_vram_write), 0);
      chk("arst_addr", int'(o_vram_addr), 0);
      chk("arst_data", int'(o_vram_data), 0);
      chk("arst_sel", int'(o_vram_sel), 0);
      chk("arst_busy", int'(o_busy), 0);
      chk("arst_ready", int'(o_ready), 0);
      chk("arst_done_err", int'({o_done, o_err}), 0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // 2: clean frame, back-to-back bytes
      s = '{8'h00, 8'hA5, 8'h01, 8'h05, 8'h0A, 8'h3F, 8'h00};
      add_trailer(s, 1'b1);
      run_frame("clean", s, 0);
      if (got_cyc.size() == DEPTH)
         chk("clean_rate", got_cyc[DEPTH-1] - got_cyc[0], DEPTH - 1);
      else
         chk("clean_rate_n", got_cyc.size(), DEPTH);

      // 3: valid toggling through PIX
      got.delete();
      done_cnt = 0;
      pulse_start();
      send('{8'hA5, 8'h00}, 0);
      s2 = '{8'h11, 8'h22, 8'h33, 8'h04};
      add_trailer(s2, 1'b1);
      foreach (s2[k]) begin
         @(negedge i_clk);
         i_valid = 1'b0;
         send('{s2[k]}, 0);
      end
      wait_idle();
      s = '{8'hA5, 8'h00};
      foreach (s2[k]) s.push_back(s2[k]);
      check_frame("bp", s);

      // 4: bad select, start ignored while busy, err sticky until next start
      got.delete();
      done_cnt = 0;
      pulse_start();
      send('{8'hA5, 8'h07}, 0);
      chk("badsel_err", int'(o_err), 1);
      pulse_start();
      chk("badsel_start_ign", int'(o_err), 1);
      s2 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h3E};
      add_trailer(s2, 1'b1);
      send(s2, 0);
      wait_idle();
      s = '{8'hA5, 8'h07};
      foreach (s2[k]) s.push_back(s2[k]);
      check_frame("badsel", s);
      repeat (3) @(negedge i_clk);
      chk("badsel_sticky", int'(o_err), 1);

      // 5: out-of-range pixel truncated, err set
      s = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h45, 8'h03};
      add_trailer(s, 1'b1);
      run_frame("range", s, 0);

`ifdef VRAM_LOADER_CHECKSUM_EN
      // 6: trailer compare
      run_frame("cks_ok", '{8'hA5, 8'h01, 8'h05, 8'h0A, 8'h3F, 8'h00, 8'h4E}, 0);
      run_frame("cks_bad", '{8'hA5, 8'h01, 8'h05, 8'h0A, 8'h3F, 8'h00, 8'h4F}, 0);
`endif

      // randomized frames
      for (int f = 0; f < 8; f++) begin
         int junk;
         s.delete();
         junk = $urandom_range(3);
         for (int j = 0; j < junk; j++) s.push_back(8'($urandom_range(8'hA4)));
         s.push_back(8'hA5);
         if ($urandom_range(3) == 0) begin
            s.push_back(8'($urandom_range(8'hFF, 8'h02)));
            s.push_back(8'hA5);
         end
         s.push_back(8'($urandom_range(1)));
         for (int p = 0; p < DEPTH; p++) begin
            if ($urandom_range(4) == 0) s.push_back(8'($urandom_range(255)));
            else s.push_back(8'($urandom_range(63)));
         end
         add_trailer(s, $urandom_range(1) == 1);
         run_frame($sformatf("rnd%0d", f), s, $urandom_range(50));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      bail("global");
   end

endmodule
